lock_supervisor: RTL and testbench

LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

---
 rtl/lock_supervisor.sv | 146 ++++++++++++++
 tb/tb_lock_supervisor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lock_supervisor.sv
// lock_supervisor: supervises a digit-entry lock. It turns raw button levels
// into single-cycle enter/lock pulses, counts consecutive failed digits,
// enforces a timed lockout, and re-issues lock pulses while the door stays open.
// Optional feature: define AUTO_RELOCK_EN to enable the OPEN-state relock timer.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_READY   | accepting digits, counting consecutive failures
// ST_OPEN    | door open, waiting for a lock request (button or relock timer)
// ST_LOCKOUT | entry suppressed for LOCKOUT_CYCLES cycles
module lock_supervisor #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [15:0] LOCKOUT_CYCLES = 16'd1000,
  parameter logic [15:0] RELOCK_CYCLES  = 16'd5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_btn,
  input  logic       lock_btn,
  input  logic [2:0] lock_state,
  input  logic       door_open,
  output logic       enter_out,
  output logic       lock_out,
  output logic       lockout,
  output logic [2:0] fail_count
);

  typedef enum logic [1:0] {ST_READY, ST_OPEN, ST_LOCKOUT} state_t;

  localparam logic [3:0] MAX_F4 = 4'(MAX_FAILS);
  localparam logic [2:0] MAX_F3 = 3'(MAX_FAILS);

  state_t      r_state;
  logic        r_enter_q;
  logic        r_lock_q;
  logic        r_enter_out;
  logic        r_lock_out;
  logic        r_lockout;
  logic        r_chk;
  logic        r_lock_fired;
  logic [1:0]  r_retry;
  logic [2:0]  r_fail_count;
  logic [15:0] r_timer;

  logic w_rise_e;
  logic w_rise_l;
  logic w_fail;
  logic w_fail_max;
  logic w_relock;

  assign w_rise_e   = enter_btn & ~r_enter_q;
  assign w_rise_l   = lock_btn & ~r_lock_q;
  // The lock has already reacted to the digit by the cycle r_chk is high;
  // landing back in s0 means the digit was wrong.
  assign w_fail     = r_chk & (lock_state == 3'd0);
  assign w_fail_max = (({1'b0, r_fail_count} + 4'd1) == MAX_F4);

`ifdef AUTO_RELOCK_EN
  assign w_relock = (r_timer == 16'd0);
`else
  assign w_relock = 1'b0;
`endif

  // Edge detection, failure tracking, timers and the supervisor FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_READY;
      r_enter_q    <= 1'b0;
      r_lock_q     <= 1'b0;
      r_enter_out  <= 1'b0;
      r_lock_out   <= 1'b0;
      r_lockout    <= 1'b0;
      r_chk        <= 1'b0;
      r_lock_fired <= 1'b0;
      r_retry      <= 2'd0;
      r_fail_count <= 3'd0;
      r_timer      <= 16'd0;
    end else begin
      r_enter_q   <= enter_btn;
      r_lock_q    <= lock_btn;
      r_enter_out <= 1'b0;
      r_lock_out  <= 1'b0;
      r_chk       <= r_enter_out & (lock_state <= 3'd3);
      case (r_state)
        ST_READY: begin
          if (door_open) begin
            r_state      <= ST_OPEN;
            r_fail_count <= 3'd0;
            r_timer      <= RELOCK_CYCLES - 16'd1;
            r_lock_fired <= 1'b0;
            r_retry      <= 2'd0;
            r_chk        <= 1'b0;
          end else if (w_fail && w_fail_max) begin
            r_state      <= ST_LOCKOUT;
            r_timer      <= LOCKOUT_CYCLES - 16'd1;
            r_fail_count <= MAX_F3;
            r_lockout    <= 1'b1;
            r_chk        <= 1'b0;
          end else begin
            if (w_fail) r_fail_count <= r_fail_count + 3'd1;
            r_enter_out <= w_rise_e;
          end
        end
        ST_OPEN: begin
          if (!door_open) begin
            r_state      <= ST_READY;
            r_lock_fired <= 1'b0;
            r_retry      <= 2'd0;
          end else begin
`ifdef AUTO_RELOCK_EN
            if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;
`endif
            // One requested lock pulse per visit; retries repeat every two
            // cycles for as long as the door refuses to close.
            if ((w_rise_l || w_relock) && !r_lock_fired) begin
              r_lock_out   <= 1'b1;
              r_lock_fired <= 1'b1;
              r_retry      <= 2'd2;
            end else if (r_retry == 2'd1) begin
              r_lock_out <= 1'b1;
              r_retry    <= 2'd2;
            end else if (r_retry != 2'd0) begin
              r_retry <= r_retry - 2'd1;
            end
          end
        end
        ST_LOCKOUT: begin
          if (r_timer == 16'd0) begin
            r_state      <= ST_READY;
            r_lockout    <= 1'b0;
            r_fail_count <= 3'd0;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  assign enter_out  = r_enter_out;
  assign lock_out   = r_lock_out;
  assign lockout    = r_lockout;
  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor with a behavioural combination-lock model
// (code 2-3-4-6) attached to enter_out/lock_out.
module tb_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter_btn = 1'b0;
  logic       lock_btn = 1'b0;
  logic [2:0] lock_state;
  logic       door_open;
  logic       enter_out;
  logic       lock_out;
  logic       lockout;
  logic [2:0] fail_count;

  int n_checks = 0;
  int n_errors = 0;

  int x = 0;
  logic [2:0] m_state = 3'd0;
  logic m_ignore_lock = 1'b0;

  int cyc = 0;
  int n_enter_rise = 0, n_enter_hi = 0, n_lock_rise = 0;
  logic prev_e = 1'b0, prev_l = 1'b0, prev_d = 1'b0;
  int t_door = 0, t_lock = 0;

  lock_supervisor #(
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(16'd1000),
    .RELOCK_CYCLES (16'd20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enter_btn (enter_btn),
    .lock_btn  (lock_btn),
    .lock_state(lock_state),
    .door_open (door_open),
    .enter_out (enter_out),
    .lock_out  (lock_out),
    .lockout   (lockout),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Combination lock model: advances on correct digits, closes on lock_out.
  always @(posedge clk) begin
    if (reset) m_state <= 3'd0;
    else if (lock_out && !m_ignore_lock) m_state <= 3'd0;
    else if (enter_out) begin
      case (m_state)
        3'd0: m_state <= (x == 2) ? 3'd1 : 3'd0;
        3'd1: m_state <= (x == 3) ? 3'd2 : 3'd0;
        3'd2: m_state <= (x == 4) ? 3'd3 : 3'd0;
        3'd3: m_state <= (x == 6) ? 3'd4 : 3'd0;
        default: m_state <= m_state;
      endcase
    end
  end
  assign lock_state = m_state;
  assign door_open  = (m_state == 3'd4);

  always @(posedge clk) cyc++;

  // Pulse monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (enter_out) n_enter_hi++;
    if (enter_out && !prev_e) n_enter_rise++;
    if (lock_out && !prev_l) begin n_lock_rise++; t_lock = cyc; end
    if (door_open && !prev_d) t_door = cyc;
    prev_e = enter_out;
    prev_l = lock_out;
    prev_d = door_open;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enter_btn = 1'b0; lock_btn = 1'b0; x = 0; m_ignore_lock = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic press_digit(input int d);
    x = d;
    enter_btn = 1'b1;
    tick(1);
    enter_btn = 1'b0;
    tick(4);
  endtask

  task automatic enter_code();
    press_digit(2); press_digit(3); press_digit(4); press_digit(6);
  endtask

  initial begin
    int s_rise, s_hi, s_lock, cnt;

    // Reset state
    tick(2);
    reset = 1'b0;
    tick(1);
    check_val("rst_enter_out", enter_out, 0);
    check_val("rst_lock_out", lock_out, 0);
    check_val("rst_lockout", lockout, 0);
    check_val("rst_fail_count", fail_count, 0);
    check_val("rst_door_open", door_open, 0);

    // Scenario 1: correct code opens the door
    s_rise = n_enter_rise; s_hi = n_enter_hi;
    enter_code();
    check_val("s1_enter_pulses", n_enter_rise - s_rise, 4);
    check_val("s1_enter_hi_cycles", n_enter_hi - s_hi, 4);
    check_val("s1_door_open", door_open, 1);
    check_val("s1_fail_count", fail_count, 0);

    // Scenario 4: lock button in OPEN
    s_lock = n_lock_rise;
    lock_btn = 1'b1;
    tick(1);
    check_val("s4_lock_out_hi", lock_out, 1);
    tick(1);
    check_val("s4_lock_out_lo", lock_out, 0);
    check_val("s4_door_closed", door_open, 0);
    tick(2);
    lock_btn = 1'b0;
    check_val("s4_lock_pulses", n_lock_rise - s_lock, 1);
    s_rise = n_enter_rise;
    press_digit(2);
    check_val("s4_ready_accepts", n_enter_rise - s_rise, 1);

    // Lock button outside OPEN is ignored
    do_reset();
    s_lock = n_lock_rise;
    lock_btn = 1'b1; tick(1); lock_btn = 1'b0; tick(3);
    check_val("lock_btn_ready_ignored", n_lock_rise - s_lock, 0);

    // Scenario 3: held enter button
    s_rise = n_enter_rise; s_hi = n_enter_hi;
    x = 2; enter_btn = 1'b1; tick(50); enter_btn = 1'b0; tick(3);
    check_val("s3_held_pulses", n_enter_rise - s_rise, 1);
    check_val("s3_held_hi_cycles", n_enter_hi - s_hi, 1);
    do_reset();

    // Scenario 2: three wrong digits -> lockout
    press_digit(9);
    check_val("s2_fail_1", fail_count, 1);
    press_digit(9);
    check_val("s2_fail_2", fail_count, 2);
    x = 9; enter_btn = 1'b1; tick(1); enter_btn = 1'b0; tick(2);
    check_val("s2_lockout_on", lockout, 1);
    check_val("s2_fail_3", fail_count, 3);
    s_rise = n_enter_rise;
    cnt = 0;
    for (int i = 0; i < 2000 && lockout; i++) begin
      cnt++;
      enter_btn = ((i % 20) < 2);
      tick(1);
    end
    enter_btn = 1'b0;
    tick(3);
    check_val("s2_lockout_cycles", cnt, 1000);
    check_val("s2_no_enter_in_lockout", n_enter_rise - s_rise, 0);
    check_val("s2_fail_cleared", fail_count, 0);

    // Scenario 6: reset in the middle of lockout
    do_reset();
    press_digit(9); press_digit(9); press_digit(9);
    tick(500);
    reset = 1'b1; tick(1); reset = 1'b0;
    check_val("s6_lockout_cleared", lockout, 0);
    check_val("s6_fail_cleared", fail_count, 0);
    enter_code();
    check_val("s6_entry_accepted", door_open, 1);

    // Lock retry while the door stays open
    m_ignore_lock = 1'b1;
    lock_btn = 1'b1;
    tick(1);
    check_val("retry_first", lock_out, 1);
    tick(1);
    check_val("retry_gap", lock_out, 0);
    tick(1);
    check_val("retry_second", lock_out, 1);
    m_ignore_lock = 1'b0;
    lock_btn = 1'b0;
    tick(3);
    check_val("retry_door_closed", door_open, 0);

    // Scenario 5: auto relock
    do_reset();
    s_lock = n_lock_rise;
    enter_code();
`ifdef AUTO_RELOCK_EN
    for (int i = 0; i < 100 && n_lock_rise == s_lock; i++) tick(1);
    check_val("s5_relock_pulses", n_lock_rise - s_lock, 1);
    check_val("s5_relock_delay", t_lock - t_door, 21);
`else
    tick(100);
    check_val("s5_no_relock", n_lock_rise - s_lock, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
